// File: rtl/next_pc_unit.sv
// ----------------------------------------------------------------------------
// next_pc_unit
// Program counter and next-PC selection for a simple two-phase fetch/execute
// core. It holds the PC, requests the instruction at PC from instruction
// memory, and once the instruction is valid it picks the next PC from the
// control inputs (sequential, branch, jump, register).
//
// Ports
//   clk            system clock, rising-edge active
//   rst            asynchronous active-high reset
//   ShiftedOffset  branch offset, already sign-extended and shifted by 2
//   JumpIndex      J-type 26-bit instruction index
//   RegTarget      JR register target
//   PCSrc          next-PC select: 00 seq, 01 branch, 10 jump, 11 register
//   BranchTaken    branch condition, only used with PCSrc = 01
//   Stall          hold the current instruction in EXEC
//   ImemAck        instruction memory completes the fetch at ImemAddr
//   ImemReq        fetch request (high throughout FETCH)
//   ImemAddr       fetch address, always equal to PC
//   PC             current program counter
//   PCPlus4        PC + 4, combinational, wraps modulo 2^32
//   InstrValid     instruction is current, control inputs are sampled
//   AlignErr       sticky flag: a misaligned next PC was selected
// ----------------------------------------------------------------------------
module next_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ShiftedOffset,
    input  logic [25:0] JumpIndex,
    input  logic [31:0] RegTarget,
    input  logic [1:0]  PCSrc,
    input  logic        BranchTaken,
    input  logic        Stall,
    input  logic        ImemAck,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        InstrValid,
    output logic        AlignErr
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        EXEC,
        HALT
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        req_q;
    logic        valid_q;
    logic        align_err_q;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        case (PCSrc)
            2'b00:   next_pc = pc_plus4;
            2'b01:   next_pc = BranchTaken ? (pc_plus4 + ShiftedOffset) : pc_plus4;
            2'b10:   next_pc = {pc_plus4[31:28], JumpIndex, 2'b00};
            default: next_pc = RegTarget;
        endcase
    end

    // Outputs are registered alongside the state so that each one is a
    // direct function of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: begin
                    if (ImemAck) begin
                        state_q <= EXEC;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (!Stall) begin
                        valid_q <= 1'b0;
                        if (next_pc[1:0] != 2'b00) begin
                            // Misaligned target: freeze PC and stop fetching.
                            state_q     <= HALT;
                            align_err_q <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                            pc_q    <= next_pc;
                            req_q   <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= HALT;
                end
            endcase
        end
    end

    assign ImemReq    = req_q;
    assign ImemAddr   = pc_q;
    assign PC         = pc_q;
    assign PCPlus4    = pc_plus4;
    assign InstrValid = valid_q;
    assign AlignErr   = align_err_q;

endmodule
